// File: rtl/sd_cmd_if.sv
// Controller-facing command/response bundle of the SD CMD-line bit engine.
// master = CMD sequencing controller, slave = sd_cmd_serdes.
interface sd_cmd_if;
    logic [31:0]  argument;
    logic [5:0]   command_index;
    logic [1:0]   response_type;
    logic         command_index_check;
    logic         command_crc_check;
    logic         issue;
    logic [119:0] response;
    logic         command_end;
    logic         command_complete;
    logic         index_error;
    logic         crc_error;
    logic         end_bit_error;
    logic         timeout_error;
    logic         conflict_error;

    modport master (
        output argument, command_index, response_type, command_index_check,
               command_crc_check, issue,
        input  response, command_end, command_complete, index_error, crc_error,
               end_bit_error, timeout_error, conflict_error
    );

    modport slave (
        input  argument, command_index, response_type, command_index_check,
               command_crc_check, issue,
        output response, command_end, command_complete, index_error, crc_error,
               end_bit_error, timeout_error, conflict_error
    );
endinterface

// File: rtl/sd_cmd_serdes.sv
// SD CMD-line bit engine: serialises a 48-bit command with CRC7, then captures the response.
// Optional macro SD_CMD_NCC_GAP_EN inserts an 8-cycle Ncc gap before completion is reported.
//
// state      | meaning
// IDLE       | pin released, waiting for issue
// TX         | driving the 48-bit command frame MSB first
// TURN       | 2-cycle bus turnaround, pin ignored (first cycle is the release cycle)
// WAIT_START | hunting for the response start bit, Ncr timer running
// RX         | shifting in the remaining response bits
// DONE       | completion and error flags (or entry to GAP when the gap is enabled)
// GAP        | Ncc spacing, completion reported on its last cycle
module sd_cmd_serdes #(
    parameter bit ConflictDetection = 1'b0,
    parameter int NcrTimeout        = 64
) (
    input  logic    sdclk_i,
    input  logic    rst_cmd_ni,
    sd_cmd_if.slave bus,
    input  logic    cmd_i,
    output logic    cmd_o,
    output logic    cmd_t
);
    localparam int NcrW = $clog2(NcrTimeout) + 1;

    typedef enum logic [2:0] {
        IDLE, TX, TURN, WAIT_START, RX, DONE
`ifdef SD_CMD_NCC_GAP_EN
        , GAP
`endif
    } state_e;

    function automatic logic [6:0] crc7(input logic [119:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 119; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    state_e          state_q, state_d;
    logic            cmd_q;
    logic [47:0]     tx_sr;
    logic            tx_prev;
    logic [7:0]      bit_cnt;
    logic [NcrW-1:0] ncr_cnt;
    logic [127:0]    rx_sr;
    logic [5:0]      idx_q;
    logic [1:0]      type_q;
    logic            idx_chk_q, crc_chk_q;
    logic            to_q, cf_q;
    logic [119:0]    resp_q;
`ifdef SD_CMD_NCC_GAP_EN
    logic [2:0]      gap_cnt;
`endif

    logic [39:0]  tx_hdr;
    logic [47:0]  tx_frame;
    logic         conflict, complete, end_pulse;
    logic         is_r2, rx_valid;
    logic [6:0]   crc_calc;
    logic [119:0] resp_new;

    assign tx_hdr   = {2'b01, bus.command_index, bus.argument};
    assign tx_frame = {tx_hdr, crc7({80'd0, tx_hdr}), 1'b1};

    // The pin sample in cmd_q reflects the bit driven one cycle earlier.
    assign conflict = ConflictDetection && (state_q == TX) && (bit_cnt != 8'd47)
                      && (cmd_q != tx_prev);

    assign is_r2    = (type_q == 2'b01);
    assign rx_valid = (type_q != 2'b00) && !to_q && !cf_q;
    assign crc_calc = is_r2 ? crc7(rx_sr[127:8]) : crc7({80'd0, rx_sr[47:8]});
    assign resp_new = rx_valid ? (is_r2 ? rx_sr[127:8] : {88'd0, rx_sr[39:8]}) : resp_q;

    always_ff @(posedge sdclk_i) begin
        if (!rst_cmd_ni) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_t     = 1'b1;
        cmd_o     = 1'b1;
        end_pulse = 1'b0;
        complete  = 1'b0;
        unique case (state_q)
            IDLE:       if (bus.issue) state_d = TX;
            TX: begin
                cmd_t     = 1'b0;
                cmd_o     = tx_sr[47];
                end_pulse = (bit_cnt == 8'd0) && !conflict;
                if (conflict)               state_d = DONE;
                else if (bit_cnt == 8'd0)   state_d = TURN;
            end
            TURN:       if (type_q == 2'b00)     state_d = DONE;
                        else if (bit_cnt == 8'd0) state_d = WAIT_START;
            WAIT_START: if (!cmd_q)              state_d = RX;
                        else if (ncr_cnt == '0)   state_d = DONE;
            RX:         if (bit_cnt == 8'd0)     state_d = DONE;
`ifdef SD_CMD_NCC_GAP_EN
            DONE:       state_d = GAP;
            GAP: begin
                if (gap_cnt == 3'd0) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
`else
            DONE: begin
                complete = 1'b1;
                state_d  = IDLE;
            end
`endif
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge sdclk_i) begin
        if (!rst_cmd_ni) begin
            cmd_q     <= 1'b1;
            tx_sr     <= '0;
            tx_prev   <= 1'b1;
            bit_cnt   <= '0;
            ncr_cnt   <= '0;
            rx_sr     <= '0;
            idx_q     <= '0;
            type_q    <= '0;
            idx_chk_q <= 1'b0;
            crc_chk_q <= 1'b0;
            to_q      <= 1'b0;
            cf_q      <= 1'b0;
            resp_q    <= '0;
`ifdef SD_CMD_NCC_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            cmd_q  <= cmd_i;
            resp_q <= bus.response;
            unique case (state_q)
                IDLE: begin
                    if (bus.issue) begin
                        tx_sr     <= tx_frame;
                        bit_cnt   <= 8'd47;
                        idx_q     <= bus.command_index;
                        type_q    <= bus.response_type;
                        idx_chk_q <= bus.command_index_check;
                        crc_chk_q <= bus.command_crc_check;
                        rx_sr     <= '0;
                        to_q      <= 1'b0;
                        cf_q      <= 1'b0;
                    end
                end
                TX: begin
                    tx_sr   <= {tx_sr[46:0], 1'b1};
                    tx_prev <= tx_sr[47];
                    bit_cnt <= bit_cnt - 8'd1;
                    if (conflict) cf_q <= 1'b1;
                    if (bit_cnt == 8'd0) begin
                        bit_cnt <= 8'd1;
                        ncr_cnt <= NcrW'(NcrTimeout - 1);
                    end
                end
                TURN: begin
                    bit_cnt <= bit_cnt - 8'd1;
                    ncr_cnt <= ncr_cnt - NcrW'(1);
                end
                WAIT_START: begin
                    ncr_cnt <= ncr_cnt - NcrW'(1);
                    if (!cmd_q) begin
                        rx_sr   <= {rx_sr[126:0], cmd_q};
                        bit_cnt <= is_r2 ? 8'd134 : 8'd46;
                    end else if (ncr_cnt == '0) begin
                        to_q <= 1'b1;
                    end
                end
                RX: begin
                    rx_sr   <= {rx_sr[126:0], cmd_q};
                    bit_cnt <= bit_cnt - 8'd1;
                end
`ifdef SD_CMD_NCC_GAP_EN
                DONE:    gap_cnt <= 3'd7;
                GAP:     gap_cnt <= gap_cnt - 3'd1;
`endif
                default: ;
            endcase
        end
    end

    assign bus.command_end      = end_pulse;
    assign bus.command_complete = complete;
    assign bus.response         = complete ? resp_new : resp_q;
    assign bus.index_error      = complete && rx_valid && idx_chk_q && !is_r2
                                  && (rx_sr[45:40] != idx_q);
    assign bus.crc_error        = complete && rx_valid && crc_chk_q && (crc_calc != rx_sr[7:1]);
    assign bus.end_bit_error    = complete && rx_valid && !rx_sr[0];
    assign bus.timeout_error    = complete && to_q;
    assign bus.conflict_error   = complete && ConflictDetection && cf_q;
endmodule

// File: doc/sd_cmd_serdes.md
Name: sd_cmd_serdes

Overview:
CMD-line bit engine sitting directly below the CMD sequencing controller. It accepts one issue pulse with index/argument/response config, serialises the 48-bit command frame with CRC7 onto the CMD pin, then deserialises the card response and returns its payload plus per-command error flags. It drives the pad through cmd_o/cmd_t and returns one completion pulse per command.

Parameters:
ConflictDetection, 0, 1 = compare the driven CMD bit against the sampled pin and abort on mismatch.
NcrTimeout, 64, sdclk cycles allowed between CMD release and the response start bit.

Ports:
sdclk_i  input  1  SD clock; all logic on rising edge.
rst_cmd_ni  input  1  reset, synchronous, active-low.
argument_i  input  32  command argument; sampled on issue.
command_index_i  input  6  command index; sampled on issue.
response_type_i  input  2  00 none, 01 136-bit R2, 10 48-bit, 11 48-bit busy (busy handled by DAT logic); sampled on issue.
command_index_check_i  input  1  check response index; sampled on issue.
command_crc_check_i  input  1  check response CRC; sampled on issue.
issue_i  input  1  one-cycle pulse starting a command.
response_o  output  120  response payload.
command_end_o  output  1  pulse: command end bit on pin.
command_complete_o  output  1  pulse: command finished (success or error).
index_error_o  output  1  valid with complete.
crc_error_o  output  1  valid with complete.
end_bit_error_o  output  1  valid with complete.
timeout_error_o  output  1  valid with complete.
conflict_error_o  output  1  valid with complete.
cmd_i  input  1  CMD pin input (async).
cmd_o  output  1  CMD pin drive value.
cmd_t  output  1  tristate enable, 1 = released/input.

Behaviour:
- Reset: state IDLE; cmd_t=1, cmd_o=1, response_o=0, all pulses and error flags 0, counters 0.
- cmd_i passes through one input register (cmd_q) before any use.
- States: IDLE, TX, TURN, WAIT_START, RX, DONE.
- IDLE: issue_i=1 -> latch config, build frame {0,1,index[5:0],arg[31:0],crc7,1}; go TX. issue_i outside IDLE is ignored; the upstream controller never issues while a command is in flight.
- TX: the cycle after issue, cmd_t=0 and cmd_o=start bit; one bit per cycle, MSB first, 48 cycles. command_end_o=1 in the same cycle the end bit is on cmd_o.
- Release: cmd_t=1, cmd_o=1 the cycle after the end bit.
- Type 00: DONE directly; command_complete_o pulses the cycle after release, with no errors.
- TURN: 2 cycles in which cmd_q is ignored (bus turnaround). Then WAIT_START.
- WAIT_START: cmd_q=0 -> RX. Timeout counter counts from the release cycle. If it reaches NcrTimeout with no start bit -> DONE with timeout_error_o=1.
- RX: shift in 47 more bits for 48-bit responses or 135 for R2, then go to DONE.
- 48-bit response: response_o[31:0]=bits[39:8], response_o[119:32]=0.
- R2 response: response_o[119:0]=bits[127:8].
- response_o updates only on complete and otherwise holds.
- CRC7: polynomial x^7+x^3+1, init 0.
  - TX covers the 40 bits before the CRC.
  - RX 48-bit covers bits[47:8].
  - RX R2 covers bits[127:8].
- crc_error_o = check enabled and CRC mismatch.
- index_error_o = check enabled, 48-bit type, and bits[45:40] != latched index. Never set for R2.
- end_bit_error_o = received final bit is 0.
- DONE: command_complete_o=1 for one cycle together with the error flags, then IDLE. Error flags are 0 in all other cycles.
- ConflictDetection=1, during TX: if cmd_q differs from the bit driven in the previous cycle, then:
  - next cycle: cmd_t=1;
  - no command_end_o;
  - DONE with conflict_error_o=1;
  - no response phase.
- ConflictDetection=0: conflict_error_o is tied 0.
- Reset mid-command: the next edge with rst_cmd_ni=0 returns to the reset state immediately and releases the pin.

Optional Feature:
SD_CMD_NCC_GAP_EN: when defined, DONE is followed by state GAP of 8 cycles (Ncc), with cmd_t=1. command_complete_o and the error flags are emitted on the last GAP cycle, and IDLE is entered afterwards, so a following issue always respects Ncc >= 8. Without the macro, completion is emitted in DONE as described above.

Test Plan:
- CMD0, arg 0x00000000, type 00 -> 48 cycles on pin: 0x40_0000_0000_95. command_end_o on bit 48; complete one cycle after release; all errors 0.
- CMD8, arg 0x000001AA, type 10, checks on; card replies 0x08_0000_01AA_13 starting 5 cycles after release -> TX frame 0x48_0000_01AA_87. response_o[31:0]=0x000001AA; no errors.
- Same CMD8 with response CRC byte 0x15 -> crc_error_o=1 with complete. With command_crc_check_i=0 -> no error.
- CMD8 with response index 0x09 -> index_error_o=1. With response end bit 0 -> end_bit_error_o=1.
- CMD2, type 01, no card response for 64 cycles -> timeout_error_o=1 with complete, response_o unchanged.
- ConflictDetection=1: force cmd_i=0 during the argument phase -> cmd_t=1 next cycle, conflict_error_o=1, no command_end_o. Reset asserted mid-RX -> cmd_t=1 and idle one cycle later.
